data_unpack: RTL and testbench
==============================

// Module: data_unpack
// PURPOSE
//  Unpacks one wide output-buffer word (2*data_width*be_parallelism bits) into NUM_BEAT
//  consecutive BAND_WIDTH-bit beats for the DDR write path; the mirror of the input-side
//  packer. Sits between the backend result buffer and the DDR write channel.
//  data_pack(data_unpack(x)) == x.
// PARAMETERS
//  be_parallelism  32   backend lanes per wide word
//  data_width      16   bits per element half; wide word = 2*data_width*be_parallelism
//  BAND_WIDTH      256  DDR beat width; must divide wide word width
//  NUM_BEAT        (derived localparam) = 2*data_width*be_parallelism/BAND_WIDTH, default 4
// PORTS
//  clk     in   1             single clock, all logic posedge
//  rst     in   1             synchronous reset, active-high
//  up_dat  in   2*dw*bp       wide word from result buffer
//  up_vld  in   1             up_dat valid
//  up_rdy  out  1             unpacker can accept a wide word this cycle
//  dn_dat  out  BAND_WIDTH    DDR beat
//  dn_vld  out  1             dn_dat valid
//  dn_rdy  in   1             DDR channel accepts beat
//  busy    out  1             a word is held (state SEND)
// BEHAVIOUR
//  - Reset: dn_vld=0, busy=0, dn_dat=0, beat_cnt=0, state=IDLE; rst mid-word drops the word.
//  - FSM IDLE/SEND. IDLE: up_rdy=1; up_vld&up_rdy -> load shift reg, beat_cnt=0, go SEND.
//  - SEND: dn_vld=1; dn_dat = slice NUM_BEAT-1-beat_cnt (MSB slice first, LSB slice last),
//    matching packer order (first-arrived beat lands in MSBs).
//  - Beat accepted on dn_vld&dn_rdy: beat_cnt++; dn_dat/dn_vld otherwise held stable.
//  - Last beat (beat_cnt==NUM_BEAT-1) accepted: up_rdy=dn_rdy combinationally; if up_vld,
//    next word loads same cycle, stay SEND, beat_cnt=0 (no bubble); else go IDLE, dn_vld=0.
//  - up_rdy=0 in SEND except on the accepted last beat. Never drops or duplicates a beat.
//  - Latency: word accepted cycle T -> first beat dn_vld at T+1. Throughput 1 beat/cycle
//    with dn_rdy=1 and up_vld held: NUM_BEAT cycles per word.
//  - NUM_BEAT==1: pass-through register, beat_cnt width forced to >=1 bit.
//  - dn_rdy low indefinitely: output holds; up_vld ignored (up_rdy=0).
// CONFIGURATION
//  DATA_UNPACK_BURST_LAST_EN defined: adds ports cfg_burst_len in 8 (wide words per DDR
//   burst, 0 treated as 1) and dn_last out 1. Word counter (8b) counts accepted words;
//   dn_last=1 with the final beat of the cfg_burst_len-th word, counter then wraps to 0.
//   cfg_burst_len sampled only when counter==0. dn_last reset 0, held with dn_dat.
//  Undefined: no cfg_burst_len/dn_last ports, no word counter; behaviour otherwise identical.
// STRUCTURE
//  Shared pkg npu_dma_pkg: function calc_num_beat(dw,bp,bw), beat_cnt width
//  ($clog2, min 1), FSM state encodings ST_IDLE=0/ST_SEND=1.
//  No sub-module: shift reg, beat counter, FSM (and optional word counter) inline.
// TESTING
//  1 Reset: rst=1 3 cycles, up_vld=1 -> dn_vld=0, up_rdy=0 during rst, busy=0 after.
//  2 Single word: up_dat={64'hD..,..,64'hA..} slices S3..S0, dn_rdy=1 -> dn_dat S3,S2,S1,S0
//    on cycles T+1..T+4, dn_vld low at T+5.
//  3 Back-to-back: up_vld=1 with words W0,W1, dn_rdy=1 -> 8 contiguous beats, no bubble,
//    up_rdy pulses on cycles T and T+4.
//  4 Backpressure: dn_rdy=0 on beat 2 for 5 cycles -> dn_dat stable, up_rdy=0, no lost beat.
//  5 Reset mid-word after beat 1 -> dn_vld=0 next cycle; next word restarts at MSB slice.
//  6 DATA_UNPACK_BURST_LAST_EN, cfg_burst_len=3, 6 words -> dn_last on beats 12 and 24 only.

Source files
------------

// File: rtl/npu_dma_pkg.sv
// Shared DMA-path definitions: beat-count helpers and the unpacker FSM state encoding.
package npu_dma_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic int calc_num_beat(input int dw, input int bp, input int bw);
        return (2 * dw * bp) / bw;
    endfunction

    // Beat counter width; a single-beat word still gets a 1-bit counter.
    function automatic int calc_cnt_w(input int num_beat);
        return (num_beat > 1) ? $clog2(num_beat) : 1;
    endfunction

endpackage

// File: rtl/data_unpack.sv
// Splits one wide result-buffer word into NUM_BEAT DDR beats, MSB slice first.
// Optional burst framing (cfg_burst_len / dn_last) is enabled by DATA_UNPACK_BURST_LAST_EN.
module data_unpack
    import npu_dma_pkg::*;
#(
    parameter int be_parallelism = 32,
    parameter int data_width     = 16,
    parameter int BAND_WIDTH     = 256
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [2*data_width*be_parallelism-1:0]   up_dat,
    input  logic                                     up_vld,
    output logic                                     up_rdy,
    output logic [BAND_WIDTH-1:0]                    dn_dat,
    output logic                                     dn_vld,
    input  logic                                     dn_rdy,
`ifdef DATA_UNPACK_BURST_LAST_EN
    input  logic [7:0]                               cfg_burst_len,
    output logic                                     dn_last,
`endif
    output logic                                     busy
);

    localparam int WORD_W   = 2 * data_width * be_parallelism;
    localparam int NUM_BEAT = calc_num_beat(data_width, be_parallelism, BAND_WIDTH);
    localparam int CNT_W    = calc_cnt_w(NUM_BEAT);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEAT - 1);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic              beat_acc, last_acc, word_acc;

    always_comb begin
        state_d  = state_q;
        beat_acc = (state_q == ST_SEND) && dn_rdy;
        last_acc = beat_acc && (beat_cnt_q == LAST_BEAT);
        // Accepting the last beat frees the holding register in the same cycle.
        up_rdy   = !rst && ((state_q == ST_IDLE) || last_acc);
        word_acc = up_vld && up_rdy;
        if (word_acc) begin
            state_d = ST_SEND;
        end else if (last_acc) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            sreg_q     <= '0;
        end else begin
            state_q <= state_d;
            if (word_acc) begin
                sreg_q     <= up_dat;
                beat_cnt_q <= '0;
            end else if (beat_acc) begin
                sreg_q     <= sreg_q << BAND_WIDTH;
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    assign dn_vld = (state_q == ST_SEND);
    assign busy   = (state_q == ST_SEND);
    assign dn_dat = sreg_q[WORD_W-1 -: BAND_WIDTH];

`ifdef DATA_UNPACK_BURST_LAST_EN
    logic [7:0] word_cnt_q, burst_len_q, len_eff;
    logic       burst_end;

    // The burst length is taken live at the start of a burst and frozen for its remainder.
    always_comb begin
        len_eff   = (word_cnt_q == 8'd0) ? ((cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len)
                                         : burst_len_q;
        burst_end = (word_cnt_q == len_eff - 8'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q  <= 8'd0;
            burst_len_q <= 8'd1;
        end else if (last_acc) begin
            if (word_cnt_q == 8'd0) begin
                burst_len_q <= len_eff;
            end
            word_cnt_q <= burst_end ? 8'd0 : word_cnt_q + 8'd1;
        end
    end

    assign dn_last = dn_vld && (beat_cnt_q == LAST_BEAT) && burst_end;
`endif

endmodule

// File: tb/tb_data_unpack.sv
// Randomised scoreboard bench for data_unpack; burst-last checks follow DATA_UNPACK_BURST_LAST_EN.
module tb_data_unpack;

    localparam int BP     = 32;
    localparam int DW     = 16;
    localparam int BW     = 256;
    localparam int WORD_W = 2 * DW * BP;
    localparam int NB     = WORD_W / BW;

    typedef struct {
        logic [BW-1:0] dat;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WORD_W-1:0] up_dat = '0;
    logic              up_vld = 1'b0;
    logic              up_rdy;
    logic [BW-1:0]     dn_dat;
    logic              dn_vld;
    logic              dn_rdy = 1'b1;
    logic              busy;
`ifdef DATA_UNPACK_BURST_LAST_EN
    logic [7:0]        cfg_burst_len = 8'd3;
    logic              dn_last;
`endif

    int    checks = 0;
    int    errors = 0;
    int    last_seen = 0;
    int    bpos = 0;
    int    blen = 1;
    logic  acc_flag = 1'b0;
    logic  rand_done = 1'b0;
    beat_t q[$];

    always #5 clk = ~clk;

    data_unpack #(.be_parallelism(BP), .data_width(DW), .BAND_WIDTH(BW)) dut (
        .clk(clk),
        .rst(rst),
        .up_dat(up_dat),
        .up_vld(up_vld),
        .up_rdy(up_rdy),
        .dn_dat(dn_dat),
        .dn_vld(dn_vld),
        .dn_rdy(dn_rdy),
`ifdef DATA_UNPACK_BURST_LAST_EN
        .cfg_burst_len(cfg_burst_len),
        .dn_last(dn_last),
`endif
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a word yields NB beats, highest BW-bit slice first.
    task automatic push_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] t;
        beat_t e;
        logic lastword;
        if (bpos == 0) begin
`ifdef DATA_UNPACK_BURST_LAST_EN
            blen = (cfg_burst_len == 8'd0) ? 1 : int'(cfg_burst_len);
`else
            blen = 1;
`endif
        end
        bpos++;
        lastword = (bpos == blen);
        if (lastword) bpos = 0;
        for (int k = 0; k < NB; k++) begin
            t = w >> (BW * (NB - 1 - k));
            e.dat = t[BW-1:0];
            e.last = (k == NB - 1) && lastword;
            q.push_back(e);
        end
    endtask

    // Monitor: everything is sampled mid-cycle, after the driver has settled the inputs.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            chk("up_rdy_in_rst", {255'd0, up_rdy}, '0);
            q.delete();
            bpos = 0;
            acc_flag = 1'b0;
        end else begin
            chk("dn_vld", {255'd0, dn_vld}, {255'd0, q.size() != 0});
            chk("busy", {255'd0, busy}, {255'd0, q.size() != 0});
            chk("up_rdy", {255'd0, up_rdy},
                {255'd0, (q.size() == 0) || (q.size() == 1 && dn_rdy)});
            if (dn_vld && q.size() != 0) begin
                chk("dn_dat", dn_dat, q[0].dat);
`ifdef DATA_UNPACK_BURST_LAST_EN
                chk("dn_last", {255'd0, dn_last}, {255'd0, q[0].last});
`endif
            end
            if (dn_vld && dn_rdy && q.size() != 0) begin
                if (q[0].last) last_seen++;
                void'(q.pop_front());
            end
            acc_flag = up_vld && up_rdy;
            if (acc_flag) push_word(up_dat);
        end
    end

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic send_word(input logic [WORD_W-1:0] w);
        int n;
        up_vld = 1'b1;
        up_dat = w;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_flag && n < 300);
        checks++;
        if (!acc_flag) begin
            errors++;
            $display("FAIL accept_timeout at %0t: up_rdy never rose within %0d cycles", $time, n);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        up_vld = 1'b0;
        dn_rdy = 1'b1;
        n = 0;
        while ((q.size() != 0 || dn_vld) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_empty", {224'd0, 32'(q.size())}, '0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [BW-1:0] s3, s2, s1, s0;
        s3 = {4{64'hDDDD_DDDD_DDDD_DDDD}};
        s2 = {4{64'hCCCC_CCCC_CCCC_CCCC}};
        s1 = {4{64'hBBBB_BBBB_BBBB_BBBB}};
        s0 = {4{64'hAAAA_AAAA_AAAA_AAAA}};

        // Reset with a word offered: nothing may be accepted.
        up_vld = 1'b1;
        up_dat = rand_word();
        @(negedge clk);
        do_reset(3);
        up_vld = 1'b0;
        #1;
        chk("rst_dn_dat", dn_dat, '0);
        chk("rst_busy", {255'd0, busy}, '0);
        chk("rst_dn_vld", {255'd0, dn_vld}, '0);
        @(negedge clk);

        // Single word, then back-to-back pair.
        send_word({s3, s2, s1, s0});
        drain();
        send_word({s3, s2, s1, s0});
        send_word(rand_word());
        drain();

        // Backpressure on beat 2 with a second word waiting.
        send_word(rand_word());
        up_vld = 1'b0;
        @(negedge clk);
        dn_rdy = 1'b0;
        up_vld = 1'b1;
        up_dat = rand_word();
        repeat (5) @(negedge clk);
        dn_rdy = 1'b1;
        send_word(up_dat);
        drain();

        // Reset after the first beat has gone out; the next word restarts at its MSB slice.
        send_word(rand_word());
        up_vld = 1'b0;
        @(negedge clk);
        do_reset(1);
        send_word({s3, s2, s1, s0});
        drain();

        // Burst framing: 6 words of length-3 bursts after a fresh reset.
        do_reset(1);
        last_seen = 0;
        for (int i = 0; i < 6; i++) send_word(rand_word());
        drain();
`ifdef DATA_UNPACK_BURST_LAST_EN
        chk("burst_last_count", {224'd0, 32'(last_seen)}, {224'd0, 32'd2});
`endif

        // Random traffic with random backpressure and idle gaps.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send_word(rand_word());
                    if ($urandom_range(0, 2) == 0) begin
                        up_vld = 1'b0;
                        repeat ($urandom_range(1, 4)) @(negedge clk);
                    end
                end
                up_vld = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    dn_rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
